// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//
// Backing store at the memory end of the cache miss path. Accepts one request at a
// time from the L2. A read returns the whole aligned block containing req_addr as a
// burst of BLOCK_SIZE beats. A write stores one word and is acknowledged with a
// single-cycle wr_done pulse. Both responses start LATENCY cycles after accept.
//
// Ports
//   clk         clock, all logic on posedge
//   rst_n       synchronous reset, active-low (storage contents are kept)
//   req_valid   request present
//   req_ready   responder can accept (high only when idle)
//   req_we      1 = single-word write, 0 = block read
//   req_addr    word address; reads ignore the block-offset bits
//   req_wdata   write data
//   resp_valid  read beat valid
//   resp_ready  requester accepts the current beat
//   resp_data   read beat data
//   resp_last   final beat of a burst, qualified by resp_valid
//   wr_done     one-cycle write-completion pulse
//
// Optional build macro MEM_STATS_EN adds stat_reads, stat_writes and stat_stalls
// (16-bit saturating counters, cleared by reset).

module cache_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned BLOCK_SIZE = 16,
    parameter int unsigned LATENCY    = 4,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = DATA_WIDTH'(11'h3F3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_last,
    output logic                  wr_done
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]           stat_reads,
    output logic [15:0]           stat_writes,
    output logic [15:0]           stat_stalls
`endif
);

    localparam int unsigned OffW  = $clog2(BLOCK_SIZE);
    localparam int unsigned BeatW = (OffW > 0) ? OffW : 1;
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [BeatW-1:0]      LastBeat = BeatW'(BLOCK_SIZE - 1);
    localparam logic [CntW-1:0]       LatInit  = CntW'(LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] OffMask  = ADDR_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBurst,
        StWdone
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         lat_cnt_q, lat_cnt_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    we_q, we_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   req_base;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    load_beat;

    // Words are stored XOR-ed with DEFAULT_DATA so that zero power-up storage reads
    // back as DEFAULT_DATA without an init sweep or a reset-time clear.
    logic [DATA_WIDTH-1:0]   mem [Depth];

    assign accept   = rst_n && req_valid && (state_q == StIdle);
    assign req_base = req_addr & ~OffMask;

    always_ff @(posedge clk) begin
        if (accept && req_we) begin
            mem[req_addr] <= req_wdata ^ DEFAULT_DATA;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        base_d      = base_q;
        we_d        = we_q;
        beat_d      = beat_q;
        resp_data_d = resp_data_q;
        rd_addr     = base_q | ADDR_WIDTH'(beat_q);
        load_beat   = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    base_d    = req_base;
                    we_d      = req_we;
                    beat_d    = '0;
                    lat_cnt_d = LatInit;
                    if (LATENCY == 1) begin
                        state_d   = req_we ? StWdone : StBurst;
                        rd_addr   = req_base;
                        load_beat = !req_we;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                // Leave on the count reaching 0 so the first beat or pulse shows up
                // exactly LATENCY cycles after accept.
                if (lat_cnt_q == CntW'(1)) begin
                    state_d   = we_q ? StWdone : StBurst;
                    rd_addr   = base_q;
                    load_beat = !we_q;
                end
            end
            StBurst: begin
                if (resp_ready) begin
                    if (beat_q == LastBeat) begin
                        state_d = StIdle;
                        beat_d  = '0;
                    end else begin
                        beat_d    = beat_q + 1'b1;
                        // Offset bits of base_q are zero, so OR never carries out of
                        // the block.
                        rd_addr   = base_q | ADDR_WIDTH'(beat_q + 1'b1);
                        load_beat = 1'b1;
                    end
                end
            end
            StWdone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_beat) begin
            resp_data_d = mem[rd_addr] ^ DEFAULT_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lat_cnt_q   <= '0;
            base_q      <= '0;
            we_q        <= 1'b0;
            beat_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            base_q      <= base_d;
            we_q        <= we_d;
            beat_q      <= beat_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StBurst);
    assign resp_last  = (state_q == StBurst) && (beat_q == LastBeat);
    assign wr_done    = (state_q == StWdone);
    assign resp_data  = resp_data_q;

`ifdef MEM_STATS_EN
    logic [15:0] stat_reads_q, stat_writes_q, stat_stalls_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (accept && !req_we && (stat_reads_q != 16'hFFFF)) begin
                stat_reads_q <= stat_reads_q + 16'd1;
            end
            if (accept && req_we && (stat_writes_q != 16'hFFFF)) begin
                stat_writes_q <= stat_writes_q + 16'd1;
            end
            if (resp_valid && !resp_ready && (stat_stalls_q != 16'hFFFF)) begin
                stat_stalls_q <= stat_stalls_q + 16'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Testbench for cache_mem_responder: table of read/write requests checked against a
// reference memory through a queue of expected beats, plus hand-written reset-abort
// sequences. Inputs change and outputs are sampled on the falling clock edge.

module tb_cache_mem_responder;

    localparam int unsigned AW  = 11;
    localparam int unsigned DW  = 11;
    localparam int unsigned BS  = 16;
    localparam int unsigned LAT = 4;
    localparam logic [DW-1:0] DEF = 11'h3F3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_data;
    logic          resp_last;
    logic          wr_done;
`ifdef MEM_STATS_EN
    logic [15:0]   stat_reads, stat_writes, stat_stalls;
`endif

    always #5 clk = ~clk;

    cache_mem_responder #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BLOCK_SIZE   (BS),
        .LATENCY      (LAT),
        .DEFAULT_DATA (DEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .wr_done    (wr_done)
`ifdef MEM_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_stalls (stat_stalls)
`endif
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BS-1:0] stall_mask;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int    n_vec = 0;
    int    n_err = 0;
    int    exp_reads = 0, exp_writes = 0, exp_stalls = 0;
    logic [DW-1:0] model_mem [2**AW];
    beat_t sb [$];
    vec_t  tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats_model();
        exp_reads  = 0;
        exp_writes = 0;
        exp_stalls = 0;
    endtask

    // abort_k >= 0: reset is asserted at that cycle of the wait phase.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int abort_k);
        @(negedge clk);
        chk($sformatf("wr%0h_ready", addr), req_ready, 1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        model_mem[addr] = data;
        exp_writes++;
        for (int k = 0; k <= int'(LAT); k++) begin
            @(negedge clk);
            if (k == 0) begin
                // Junk write held on the bus; must be ignored while busy.
                req_addr  = addr ^ 11'h002;
                req_wdata = ~data;
            end
            if (k == abort_k) begin
                rst_n     = 1'b0;
                req_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                clear_stats_model();
                chk($sformatf("wr%0h_abort_ready", addr), req_ready, 1);
                for (int j = 0; j < 6; j++) begin
                    chk($sformatf("wr%0h_abort_no_done%0d", addr, j), wr_done, 0);
                    @(negedge clk);
                end
                return;
            end
            chk($sformatf("wr%0h_done_k%0d", addr, k), wr_done, (k == int'(LAT) - 1));
            chk($sformatf("wr%0h_no_valid_k%0d", addr, k), resp_valid, 0);
            if (k == int'(LAT) - 1) req_valid = 1'b0;
            if (k == int'(LAT)) chk($sformatf("wr%0h_ready_after", addr), req_ready, 1);
        end
        req_valid = 1'b0;
    endtask

    // Each set bit b of stall_mask holds resp_ready low for 2 cycles at beat b.
    // abort_after > 0: reset right after that many handshakes.
    task automatic do_read(input logic [AW-1:0] addr, input logic [BS-1:0] stall_mask,
                           input int abort_after);
        logic [AW-1:0] base;
        beat_t exp;
        int hs, first, stall_left, stalled_beat;
        base = addr & ~AW'(BS - 1);
        for (int i = 0; i < int'(BS); i++) begin
            exp.data = model_mem[base | AW'(i)];
            exp.last = (i == int'(BS) - 1);
            sb.push_back(exp);
        end
        @(negedge clk);
        chk($sformatf("rd%0h_ready", addr), req_ready, 1);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = addr;
        resp_ready = 1'b1;
        @(posedge clk);
        exp_reads++;
        hs = 0;
        first = -1;
        stall_left = 0;
        stalled_beat = -1;
        for (int k = 0; hs < int'(BS) && k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_we    = 1'b1;
                req_addr  = base | AW'(2);
                req_wdata = 11'h7AA;
            end
            chk($sformatf("rd%0h_no_wr_done_k%0d", addr, k), wr_done, 0);
            if (resp_valid) begin
                if (first < 0) begin
                    first = k;
                    chk($sformatf("rd%0h_first_beat_cycle", addr), k, LAT - 1);
                end
                exp = sb[0];
                if (stall_mask[hs] && stalled_beat != hs) begin
                    stalled_beat = hs;
                    stall_left   = 2;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    resp_ready = 1'b0;
                    exp_stalls++;
                    chk($sformatf("rd%0h_stall_data_b%0d", addr, hs), resp_data, exp.data);
                    chk($sformatf("rd%0h_stall_last_b%0d", addr, hs), resp_last, exp.last);
                end else begin
                    resp_ready = 1'b1;
                    chk($sformatf("rd%0h_data_b%0d", addr, hs), resp_data, exp.data);
                    chk($sformatf("rd%0h_last_b%0d", addr, hs), resp_last, exp.last);
                    void'(sb.pop_front());
                    hs++;
                    if (hs == int'(BS)) req_valid = 1'b0;
                    if (abort_after > 0 && hs == abort_after) begin
                        @(negedge clk);
                        rst_n     = 1'b0;
                        req_valid = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        clear_stats_model();
                        chk($sformatf("rd%0h_abort_valid", addr), resp_valid, 0);
                        chk($sformatf("rd%0h_abort_ready", addr), req_ready, 1);
                        chk($sformatf("rd%0h_abort_last", addr), resp_last, 0);
                        sb.delete();
                        return;
                    end
                end
            end else begin
                resp_ready = 1'b1;
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        chk($sformatf("rd%0h_handshakes", addr), hs, BS);
        sb.delete();
        @(negedge clk);
        chk($sformatf("rd%0h_idle_valid", addr), resp_valid, 0);
        chk($sformatf("rd%0h_idle_ready", addr), req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) model_mem[i] = DEF;

        tbl[0] = '{1'b0, 11'h123, 11'h000, 16'h0000};
        tbl[1] = '{1'b1, 11'h125, 11'h0AA, 16'h0000};
        tbl[2] = '{1'b0, 11'h120, 11'h000, 16'h0000};
        tbl[3] = '{1'b0, 11'h120, 11'h000, 16'h0088};
        tbl[4] = '{1'b1, 11'h7FF, 11'h555, 16'h0000};
        tbl[5] = '{1'b0, 11'h7F3, 11'h000, 16'h0000};
        tbl[6] = '{1'b1, 11'h000, 11'h001, 16'h0000};
        tbl[7] = '{1'b0, 11'h00F, 11'h000, 16'h8001};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_last", resp_last, 0);
        chk("reset_wr_done", wr_done, 0);
        chk("reset_resp_data", resp_data, 0);
        rst_n = 1'b1;
        clear_stats_model();

        for (int v = 0; v < 8; v++) begin
            if (tbl[v].we) do_write(tbl[v].addr, tbl[v].wdata, -1);
            else           do_read(tbl[v].addr, tbl[v].stall_mask, 0);
        end

        // Abort a burst after 5 beats, then confirm storage survived the reset.
        do_read(11'h120, 16'h0000, 5);
        do_read(11'h120, 16'h0000, 0);

        // Reset during the wait phase of a write: no pulse, data still committed.
        do_write(11'h130, 11'h222, 0);
        do_read(11'h130, 16'h0000, 0);
        do_write(11'h131, 11'h111, -1);
        do_read(11'h13C, 16'h0012, 0);

`ifdef MEM_STATS_EN
        @(negedge clk);
        chk("stat_reads", stat_reads, exp_reads);
        chk("stat_writes", stat_writes, exp_writes);
        chk("stat_stalls", stat_stalls, exp_stalls);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
